// File: rtl/writeback_unit.sv
// Final pipeline stage: merges in-order ALU results with variable-latency load
// returns, drives the register file write port and exports a pending-load mask.
module writeback_unit #(
    parameter int unsigned LOAD_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(LOAD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       ld_offset,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    output logic [4:0]       rf_write_idx,
    output logic [31:0]      rf_write_data,
    output logic             rf_write_enable,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] ld_outstanding,
    output logic             err_unexpected_rsp
);

    localparam int unsigned PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } ld_entry_t;

    ld_entry_t        q_mem [LOAD_DEPTH];
    ld_entry_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             alu_fire;
    logic [31:0]      pending_next;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;

    // Handshake decode; a load response always wins the write port
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(LOAD_DEPTH));
    assign head      = q_mem[rd_ptr];
    assign ld_ready  = !full && !((ld_rd != 5'd0) && pending_mask[ld_rd]);
    assign push      = ld_valid && ld_ready;
    assign pop       = mem_rsp_valid && !empty;
    assign alu_ready = !pop && !((alu_rd != 5'd0) && pending_mask[alu_rd]);
    assign alu_fire  = alu_valid && alu_ready;
    assign ld_outstanding = count;

    // Entry storage for issued loads awaiting their response
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= '{rd: ld_rd, funct3: ld_funct3, offset: ld_offset};
        end
    end

    // Queue pointers, occupancy and sticky unexpected-response flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (mem_rsp_valid && empty) err_unexpected_rsp <= 1'b1;
        end
    end

    // Pending mask: set on issue, cleared on the edge that writes the result
    always_comb begin
        pending_next = pending_mask;
        if (pop && (head.rd != 5'd0))  pending_next[head.rd] = 1'b0;
        if (push && (ld_rd != 5'd0))   pending_next[ld_rd]   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_mask <= '0;
        else        pending_mask <= pending_next;
    end

    // Byte/halfword extraction and extension of the returning load word
    always_comb begin
        byte_sel = mem_rsp_data[7:0];
        case (head.offset)
            2'd1:    byte_sel = mem_rsp_data[15:8];
            2'd2:    byte_sel = mem_rsp_data[23:16];
            2'd3:    byte_sel = mem_rsp_data[31:24];
            default: byte_sel = mem_rsp_data[7:0];
        endcase
        half_sel = head.offset[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (head.funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rsp_data;
        endcase
    end

    // Registered register-file write port; x0 writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_enable <= 1'b0;
            rf_write_idx    <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            if (pop) begin
                if (head.rd != 5'd0) begin
                    rf_write_enable <= 1'b1;
                    rf_write_idx    <= head.rd;
                    rf_write_data   <= load_data;
                end
            end else if (alu_fire && (alu_rd != 5'd0)) begin
                rf_write_enable <= 1'b1;
                rf_write_idx    <= alu_rd;
                rf_write_data   <= alu_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_writeback_unit;

    localparam int unsigned LOAD_DEPTH = 4;
    localparam int unsigned CNT_W      = $clog2(LOAD_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alu_valid = 1'b0;
    logic             alu_ready;
    logic [4:0]       alu_rd = '0;
    logic [31:0]      alu_data = '0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [4:0]       ld_rd = '0;
    logic [2:0]       ld_funct3 = '0;
    logic [1:0]       ld_offset = '0;
    logic             mem_rsp_valid = 1'b0;
    logic [31:0]      mem_rsp_data = '0;
    logic [4:0]       rf_write_idx;
    logic [31:0]      rf_write_data;
    logic             rf_write_enable;
    logic [31:0]      pending_mask;
    logic [CNT_W-1:0] ld_outstanding;
    logic             err_unexpected_rsp;

    writeback_unit #(.LOAD_DEPTH(LOAD_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_funct3(ld_funct3), .ld_offset(ld_offset),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rf_write_idx(rf_write_idx), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable), .pending_mask(pending_mask),
        .ld_outstanding(ld_outstanding), .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    ld_t mq[$];
    wr_t sb[$];
    logic m_err = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] b = (w >> (8 * int'(off))) & 32'hFF;
        logic [31:0] h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // One clock of stimulus; model state mirrors what the DUT holds after each edge
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic rv, input logic [31:0] rdata);
        logic [31:0] pm;
        logic m_pop, m_alu_rdy, m_ld_rdy;
        ld_t e;
        @(posedge clk); #1;
        check("pending_mask", pending_mask, model_mask());
        check("ld_outstanding", 32'(ld_outstanding), 32'(mq.size()));
        check("err_unexpected_rsp", 32'(err_unexpected_rsp), 32'(m_err));
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_offset = off;
        mem_rsp_valid = rv; mem_rsp_data = rdata;
        #1;
        pm = model_mask();
        m_pop = rv && (mq.size() != 0);
        m_alu_rdy = !m_pop && !((ard != 5'd0) && pm[ard]);
        m_ld_rdy = (mq.size() < LOAD_DEPTH) && !((lrd != 5'd0) && pm[lrd]);
        check("alu_ready", 32'(alu_ready), 32'(m_alu_rdy));
        check("ld_ready", 32'(ld_ready), 32'(m_ld_rdy));
        if (m_pop) begin
            e = mq.pop_front();
            if (e.rd != 5'd0) sb.push_back('{idx: e.rd, data: extract(e.f3, e.off, rdata), cyc: cyc + 1});
        end else if (rv) begin
            m_err = 1'b1;
        end
        if (av && m_alu_rdy && ard != 5'd0) sb.push_back('{idx: ard, data: ad, cyc: cyc + 1});
        if (lv && m_ld_rdy) mq.push_back('{rd: lrd, f3: f3, off: off});
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        step(1'b1, rd, d, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        step(1'b0, 5'd0, 32'd0, 1'b1, rd, f3, off, 1'b0, 32'd0);
    endtask

    task automatic rsp(input logic [31:0] d);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, d);
    endtask

    // Monitor: every write strobe must match the oldest expected write and its cycle
    always @(negedge clk) begin
        if (rst_n && rf_write_enable) begin
            if (sb.size() == 0) begin
                check("unexpected_write_idx", 32'(rf_write_idx), 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("write_idx", 32'(rf_write_idx), 32'(w.idx));
                check("write_data", rf_write_data, w.data);
                check("write_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_we", 32'(rf_write_enable), 32'd0);
        check("reset_idx", 32'(rf_write_idx), 32'd0);
        check("reset_data", rf_write_data, 32'd0);
        check("reset_pending", pending_mask, 32'd0);
        rst_n = 1'b1;

        // ALU write
        alu(5'd5, 32'hDEAD_BEEF);
        idle(); idle();

        // Load extraction variants
        load(5'd3, 3'b000, 2'd2); rsp(32'h1280_3456);
        load(5'd3, 3'b100, 2'd2); rsp(32'h1280_3456);
        load(5'd3, 3'b001, 2'd2); rsp(32'h1280_3456);
        load(5'd3, 3'b010, 2'd2); rsp(32'h1280_3456);
        load(5'd4, 3'b001, 2'd0); rsp(32'h0000_8001);
        load(5'd0, 3'b010, 2'd0); rsp(32'h1234_5678);
        idle();

        // WAW/RAW hazard on x7
        load(5'd7, 3'b010, 2'd0);
        step(1'b1, 5'd7, 32'h7777_7777, 1'b1, 5'd7, 3'b010, 2'd0, 1'b0, 32'd0);
        rsp(32'hCAFE_0007);
        alu(5'd7, 32'h7777_7777);
        idle();

        // Fill to full, then drain in order and wrap pointers
        for (int i = 1; i <= 4; i++) load(5'(i), 3'b010, 2'd0);
        load(5'd5, 3'b010, 2'd0);
        for (int i = 1; i <= 4; i++) rsp(32'(i * 16));
        for (int r = 0; r < 3; r++) begin
            load(5'(10 + r), 3'b100, 2'(r));
            rsp(32'hA5C3_9F17 + 32'(r));
        end
        idle();

        // Load response beats a simultaneous ALU result
        load(5'd2, 3'b010, 2'd0);
        step(1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h0000_0202);
        alu(5'd9, 32'h0000_0909);
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic rv;
            rv = (mq.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rv, $urandom);
        end
        while (mq.size() != 0) rsp($urandom);
        idle(); idle();

        // Unexpected response, then reset with loads outstanding
        rsp(32'hBAD0_BAD0);
        idle();
        load(5'd6, 3'b010, 2'd0);
        load(5'd8, 3'b010, 2'd0);
        alu(5'd1, 32'h1111_1111);
        @(posedge clk); #1;
        alu_valid = 1'b0; ld_valid = 1'b0; mem_rsp_valid = 1'b0;
        check("pre_reset_pending", pending_mask, 32'h0000_0140);
        rst_n = 1'b0;
        #1;
        check("async_we", 32'(rf_write_enable), 32'd0);
        check("async_idx", 32'(rf_write_idx), 32'd0);
        check("async_data", rf_write_data, 32'd0);
        check("async_pending", pending_mask, 32'd0);
        check("async_outstanding", 32'(ld_outstanding), 32'd0);
        check("async_err", 32'(err_unexpected_rsp), 32'd0);
        mq.delete(); sb.delete(); m_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp(32'h5555_5555);
        idle(); idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage; directly upstream of the general-purpose register file, driving its write index, write data and write enable.
- Merges two result sources: in-order ALU results, and load results that return from data memory after variable latency.
- Tracks outstanding loads in a small in-order queue, extracts and extends the loaded bytes, and exports a per-register pending mask for the hazard/stall logic.

Parameters:
LOAD_DEPTH, 4, pending-load queue depth; power of two, minimum 2.
CNT_W, $clog2(LOAD_DEPTH+1), width of the outstanding-load count.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
ld_valid  in  1  load issued to memory this cycle
ld_ready  out  1  load issue permitted
ld_rd  in  5  load destination register
ld_funct3  in  3  RISC-V load funct3
ld_offset  in  2  address bits [1:0]
mem_rsp_valid  in  1  memory read data valid; cannot be back-pressured
mem_rsp_data  in  32  aligned memory word
rf_write_idx  out  5  register file write index
rf_write_data  out  32  register file write data
rf_write_enable  out  1  register file write strobe
pending_mask  out  32  bit i high while a load to xi is outstanding; bit 0 always 0
ld_outstanding  out  CNT_W  queue occupancy
err_unexpected_rsp  out  1  sticky: response arrived with empty queue

Behaviour:
- Reset (async assert, sync release): queue empty, pending_mask=0, ld_outstanding=0, rf_write_enable=0, rf_write_idx=0, rf_write_data=0, err_unexpected_rsp=0.
- Queue: circular buffer with read and write pointers plus a count. Each entry holds {rd, funct3, offset}.
- Push on ld_valid && ld_ready. Pop on mem_rsp_valid while the queue is non-empty.
- ld_ready = !full && !(ld_rd!=0 && pending_mask[ld_rd]). It uses the current-cycle state only: no same-cycle pop bypass, and no issue to an rd that is still pending (WAW stall).
- Push with ld_rd=0: entry is queued and popped normally, but pending_mask is unchanged and no write occurs.
- alu_ready = !(mem_rsp_valid && !empty) && !(alu_rd!=0 && pending_mask[alu_rd]). A load response always has priority.
- Write outputs are registered. An accepted ALU result or popped load produces rf_write_enable=1 at the next edge, for exactly one cycle, with the matching idx and data. Latency is 1 cycle from acceptance or response.
- Writes with rd=0 are suppressed: enable stays 0.
- With no event, rf_write_enable=0 and idx/data hold their last values.
- Load extraction, from the popped entry:
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword at offset[1], sign-extended.
  - 101 LHU: halfword at offset[1], zero-extended.
  - 010, and all other codes: full word.
  - offset[0] is ignored for halves; the offset is ignored for words.
- pending_mask:
  - Bit rd is set on the edge that pushes the load.
  - Bit rd is cleared on the same edge that registers that load's write, i.e. the edge where rf_write_enable rises.
  - In that cycle, consumers forward from rf_write_*.
- Same-cycle push and pop: both occur. The count is unchanged, and the pointers advance independently.
- A push at full cannot occur because ld_ready is low.
- mem_rsp_valid with an empty queue: the response is ignored, err_unexpected_rsp is set and stays set until reset, and no write occurs.
- Pointer wrap is modulo LOAD_DEPTH.
- Reset mid-operation: all outstanding loads are discarded. Responses arriving after reset set err_unexpected_rsp.

Test Plan:
- ALU write: alu_valid, rd=5, data=0xDEADBEEF -> next cycle rf_write_enable=1, idx=5, data=0xDEADBEEF for one cycle; pending_mask=0.
- Load extraction: issue LB rd=3 offset=2, response 0x12_80_34_56 -> write x3=0xFFFFFF80. Repeat with LBU -> 0x00000080. LH offset=2 -> 0x00001280. LW -> 0x12803456.
- Pending/hazard: issue load rd=7 -> pending_mask=0x80. alu_valid with rd=7 -> alu_ready=0. A second load to rd=7 -> ld_ready=0. After the response, the bit clears on the write edge and alu_ready rises the cycle after.
- Fill and wrap: issue LOAD_DEPTH loads to x1..x4 -> ld_ready=0, ld_outstanding=4. Return responses 0x10..0x40 -> writes occur in order x1..x4, and 3 more issue/response rounds exercise pointer wrap.
- Priority: alu_valid rd=9 in the same cycle as a load response for x2 -> alu_ready=0, x2 is written first, and x9 is written the following cycle.
- Error/reset: mem_rsp_valid with an empty queue -> no write and err_unexpected_rsp=1. Assert rst_n=0 with 2 loads pending -> outputs and pending_mask clear immediately (asynchronously), and the flag clears.
